// File: rtl/pong_pkg.sv
// Shared definitions for the paddle button front end.
// Pure declarations: no logic, no latency.
// No flow control; consumers sample through their own enables.
package pong_pkg;

   // Button channel indices
   localparam int BTN_UP_P1   = 0;
   localparam int BTN_DOWN_P1 = 1;
   localparam int BTN_UP_P2   = 2;
   localparam int BTN_DOWN_P2 = 3;

   // Default timing at a 50 MHz board clock
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms to first repeat
   localparam int DEF_REPEAT_RATE     = 5000000;   // 100 ms between repeats

   // Auto-repeat state per channel
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, polarity normalise, debounce, auto-repeat move FSM.
// Raw edge to level/press/move: 2 + DEBOUNCE_CYCLES clk cycles.
// No backpressure; move is a one-cycle pulse and is dropped if not sampled.
module btn_channel
   import pong_pkg::*;
#(
   parameter logic ACTIVE_LOW      = 1'b0,
   parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int   REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int   REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic move
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int RP_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

   // Idle pin value; the synchroniser starts here so reset never looks like a press
   localparam logic RAW_IDLE = ACTIVE_LOW;

   logic            sync_1;
   logic            sync_2;
   logic            sample;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_cnt_nxt;
   logic            level_nxt;

   rpt_state_t      state;
   rpt_state_t      state_nxt;
   logic [RP_W-1:0] rp_cnt;
   logic [RP_W-1:0] rp_cnt_nxt;
   logic            move_nxt;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= RAW_IDLE;
         sync_2 <= RAW_IDLE;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   assign sample = sync_2 ^ ACTIVE_LOW;

   // Debounce: count while the sample disagrees, accept after DEBOUNCE_CYCLES in a row
   always_comb begin
      db_cnt_nxt = '0;
      level_nxt  = level;
      if (sample != level) begin
         if (db_cnt == DB_LAST) begin
            level_nxt = ~level;
         end else begin
            db_cnt_nxt = db_cnt + 1'b1;
         end
      end
   end

   // Debounced level and press pulse, registered together so they line up
   always_ff @(posedge clk) begin
      if (reset) begin
         level  <= 1'b0;
         press  <= 1'b0;
         db_cnt <= '0;
      end else begin
         level  <= level_nxt;
         press  <= level_nxt & ~level;
         db_cnt <= db_cnt_nxt;
      end
   end

   // Repeat FSM next state; it follows level_nxt so the first move coincides with press
   always_comb begin
      state_nxt  = state;
      rp_cnt_nxt = rp_cnt;
      move_nxt   = 1'b0;
      if (!level_nxt) begin
         state_nxt  = IDLE;
         rp_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (!level) begin
                  move_nxt   = 1'b1;
                  state_nxt  = DELAY;
                  rp_cnt_nxt = '0;
               end
            end
            DELAY: begin
               if (rp_cnt == DELAY_LAST) begin
                  move_nxt   = 1'b1;
                  state_nxt  = REPEAT;
                  rp_cnt_nxt = '0;
               end else begin
                  rp_cnt_nxt = rp_cnt + 1'b1;
               end
            end
            REPEAT: begin
               if (rp_cnt == RATE_LAST) begin
                  move_nxt   = 1'b1;
                  rp_cnt_nxt = '0;
               end else begin
                  rp_cnt_nxt = rp_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt  = IDLE;
               rp_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Repeat FSM state, counter and move pulse register
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rp_cnt <= '0;
         move   <= 1'b0;
      end else begin
         state  <= state_nxt;
         rp_cnt <= rp_cnt_nxt;
         move   <= move_nxt;
      end
   end

endmodule

// File: rtl/paddle_input_conditioner.sv
// Player push-button front end: per-channel conditioning plus up/down conflict mask.
// Raw edge to outputs: 2 + DEBOUNCE_CYCLES clk cycles; mask is combinational.
// No backpressure; move pulses due during a conflict are dropped, not queued.
module paddle_input_conditioner
   import pong_pkg::*;
#(
   parameter int               N_BTN           = 4,
   parameter logic [N_BTN-1:0] BTN_ACTIVE_LOW  = 4'b0101,
   parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int               REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_move
);

   logic [N_BTN-1:0] move_raw;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .ACTIVE_LOW      (BTN_ACTIVE_LOW[i]),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .move  (move_raw[i])
      );

      // Channels pair up as (up, down) per player: even index is up, odd is down
      localparam int PARTNER = i ^ 1;
      if (PARTNER < N_BTN) begin : g_pair
         assign btn_move[i] = move_raw[i] & ~(btn_level[i] & btn_level[PARTNER]);
      end else begin : g_solo
         assign btn_move[i] = move_raw[i];
      end
   end

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner with short timing parameters.
// Checks per-cycle pulse/level histories against hand-computed bit patterns.
// Stimulus is open loop; every run is a fixed number of cycles.
module tb_paddle_input_conditioner;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_move;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-channel history, bit k = value sampled after the k-th edge of a run
   logic [31:0] lv_h [NB];
   logic [31:0] pr_h [NB];
   logic [31:0] mv_h [NB];

   paddle_input_conditioner #(
      .N_BTN           (NB),
      .BTN_ACTIVE_LOW  (4'b0101),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .btn_move  (btn_move)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int ch = 0; ch < NB; ch++) begin
         lv_h[ch] = '0;
         pr_h[ch] = '0;
         mv_h[ch] = '0;
      end
      for (int k = 1; k <= n; k++) begin
         step();
         for (int ch = 0; ch < NB; ch++) begin
            lv_h[ch][k] = btn_level[ch];
            pr_h[ch][k] = btn_press[ch];
            mv_h[ch][k] = btn_move[ch];
         end
      end
   endtask

   function automatic logic [31:0] any_activity();
      logic [31:0] acc;
      acc = '0;
      for (int ch = 0; ch < NB; ch++) acc = acc | lv_h[ch] | pr_h[ch] | mv_h[ch];
      return acc;
   endfunction

   initial begin
      // 1. Reset with idle pins
      reset   = 1'b1;
      btn_raw = 4'b0101;
      run(20);
      check("reset_hold_outputs", any_activity(), 32'h0);
      check("reset_level", {28'h0, btn_level}, 32'h0);
      reset = 1'b0;
      run(20);
      check("post_reset_no_phantom", any_activity(), 32'h0);

      // 2. down_p1 press: level/press/move at +6, repeats at +16, +19, +22
      btn_raw[1] = 1'b1;
      run(24);
      check("down_p1_level",  lv_h[1], 32'h01FF_FFC0);
      check("down_p1_press",  pr_h[1], 32'h0000_0040);
      check("down_p1_move",   mv_h[1], 32'h0049_0040);
      check("others_move",    mv_h[0] | mv_h[2] | mv_h[3], 32'h0);

      // 5. Release in REPEAT: pulses at +1,+4 still due before level falls at +6
      btn_raw[1] = 1'b0;
      run(10);
      check("release_level", lv_h[1], 32'h0000_003E);
      check("release_press", pr_h[1], 32'h0);
      check("release_move",  mv_h[1], 32'h0000_0012);

      // Re-press restarts the full delay
      btn_raw[1] = 1'b1;
      run(20);
      check("repress_move", mv_h[1], 32'h0009_0040);
      btn_raw[1] = 1'b0;
      run(10);

      // 3. Three-cycle glitch on up_p1 is rejected
      btn_raw[0] = 1'b0;
      run(3);
      check("glitch_during", lv_h[0] | pr_h[0] | mv_h[0], 32'h0);
      btn_raw[0] = 1'b1;
      run(10);
      check("glitch_after", lv_h[0] | pr_h[0] | mv_h[0], 32'h0);

      // Four or more cycles low is accepted
      btn_raw[0] = 1'b0;
      run(8);
      check("up_p1_level", lv_h[0], 32'h0000_01C0);
      check("up_p1_press", pr_h[0], 32'h0000_0040);
      check("up_p1_move",  mv_h[0], 32'h0000_0040);
      btn_raw[0] = 1'b1;
      run(8);
      check("up_p1_release_level", lv_h[0], 32'h0000_003E);
      check("up_p1_release_move",  mv_h[0], 32'h0);

      // 4. Conflict on player 1 while down_p2 repeats alone
      btn_raw = 4'b1110;
      run(24);
      check("conf_level0", lv_h[0], 32'h01FF_FFC0);
      check("conf_level1", lv_h[1], 32'h01FF_FFC0);
      check("conf_press0", pr_h[0], 32'h0000_0040);
      check("conf_press1", pr_h[1], 32'h0000_0040);
      check("conf_move_p1", mv_h[0] | mv_h[1], 32'h0);
      check("conf_move_p2", mv_h[3], 32'h0049_0040);
      check("conf_level_vec", {28'h0, btn_level}, 32'h0000_000B);

      // Drop up_p1: pulses due at +1,+4 are lost, +7,+10 pass once level[0] falls
      btn_raw[0] = 1'b1;
      run(10);
      check("conf_end_move1", mv_h[1], 32'h0000_0480);
      check("conf_end_move0", mv_h[0], 32'h0);
      btn_raw = 4'b0101;
      run(10);
      check("all_released", {28'h0, btn_level}, 32'h0);

      // 6. Reset while down_p2 sits in DELAY with the pin still pressed
      btn_raw = 4'b1101;
      run(8);
      check("pre_reset_move3", mv_h[3], 32'h0000_0040);
      reset = 1'b1;
      step();
      check("mid_reset_outputs", {20'h0, btn_level, btn_press, btn_move}, 32'h0);
      reset = 1'b0;
      run(8);
      check("rerun_level3", lv_h[3], 32'h0000_01C0);
      check("rerun_press3", pr_h[3], 32'h0000_0040);
      check("rerun_move3",  mv_h[3], 32'h0000_0040);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
